// File: rtl/fb_code_gen_if.sv
// fb_code_gen_if: control inputs and phase/code outputs of the feedback code generator.
interface fb_code_gen_if #(
    parameter int GW  = 11,
    parameter int CW  = 16,
    parameter int SEL = GW - 1
);
    logic           u_d;
    logic           en;
    logic           ld;
    logic [CW-1:0]  ld_val;
    logic [GW-1:0]  gray;
    logic [SEL-1:0] strobe;
    logic           frame_start;
    logic [CW-1:0]  code;
    logic [SEL-1:0] code_sel;
    logic           sat;
    modport master (
        output u_d, en, ld, ld_val,
        input  gray, strobe, frame_start, code, code_sel, sat
    );
    modport slave (
        input  u_d, en, ld, ld_val,
        output gray, strobe, frame_start, code, code_sel, sat
    );
endinterface

// File: rtl/fb_code_gen.sv
// fb_code_gen: free-running Gray phase base with toggle strobes and a frame-synchronous up/down code.
// Define FB_CODE_SAT_EN to saturate the code at its limits and report sat; otherwise steps wrap.
module fb_code_gen #(
    parameter int GW  = 11,
    parameter int CW  = 16,
    parameter int SEL = GW - 1
) (
    input logic          clk,
    input logic          rstb,
    fb_code_gen_if.slave bus
);
    logic [GW-1:0]  bin_q, bin_d, gray_q, gray_d;
    logic [SEL-1:0] strobe_q, strobe_d;
    logic           fs_q, fs_d, sat_q, sat_d, boundary, blocked;
    logic [CW-1:0]  code_q, code_d, code_step;
    always_comb begin
        bin_d     = bin_q + GW'(1);
        gray_d    = bin_d ^ (bin_d >> 1);
        strobe_d  = gray_d[GW-1:1] ^ gray_q[GW-1:1];
        boundary  = &bin_q;
        fs_d      = boundary;
`ifdef FB_CODE_SAT_EN
        blocked   = bus.en & (bus.u_d ? &code_q : ~|code_q);
`else
        blocked   = 1'b0;
`endif
        code_step = bus.u_d ? code_q + CW'(1) : code_q - CW'(1);
        // control inputs only matter on the wrap edge, so the selected bits hold for a whole frame
        code_d    = !boundary ? code_q : bus.ld ? bus.ld_val : (bus.en & ~blocked) ? code_step : code_q;
        sat_d     = !boundary ? sat_q : ~bus.ld & blocked;
    end
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            bin_q    <= '0;
            gray_q   <= '0;
            strobe_q <= '0;
            fs_q     <= 1'b0;
            code_q   <= '0;
            sat_q    <= 1'b0;
        end else begin
            bin_q    <= bin_d;
            gray_q   <= gray_d;
            strobe_q <= strobe_d;
            fs_q     <= fs_d;
            code_q   <= code_d;
            sat_q    <= sat_d;
        end
    end
    assign bus.gray        = gray_q;
    assign bus.strobe      = strobe_q;
    assign bus.frame_start = fs_q;
    assign bus.code        = code_q;
    assign bus.code_sel    = code_q[CW-1 -: SEL];
    assign bus.sat         = sat_q;
endmodule

// File: tb/tb_fb_code_gen.sv
// tb_fb_code_gen: randomized and directed checks of fb_code_gen against a cycle-level reference model.
module tb_fb_code_gen;
    localparam int GW  = 4;
    localparam int CW  = 16;
    localparam int SEL = GW - 1;
    localparam int FRAME = 1 << GW;
    logic clk = 1'b0;
    logic rstb = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    int m_bin, m_gray, m_strobe, m_fs, m_code, m_sat;
    int cnt [SEL];
    fb_code_gen_if #(.GW(GW), .CW(CW), .SEL(SEL)) bus ();
    fb_code_gen #(.GW(GW), .CW(CW), .SEL(SEL)) dut (.clk(clk), .rstb(rstb), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask
    function automatic int gray_of(input int b);
        return b ^ (b >> 1);
    endfunction
    task automatic model_reset();
        m_bin = 0; m_gray = 0; m_strobe = 0; m_fs = 0; m_code = 0; m_sat = 0;
        foreach (cnt[i]) cnt[i] = 0;
    endtask
    task automatic model_update();
        int prev_gray;
        bit wrap, lim;
        prev_gray = gray_of(m_bin);
        wrap      = (m_bin == FRAME - 1);
        m_bin     = (m_bin + 1) % FRAME;
        m_gray    = gray_of(m_bin);
        m_strobe  = (m_gray ^ prev_gray) >> 1;
        m_fs      = wrap;
        if (wrap) begin
            lim = bus.u_d ? (m_code == 65535) : (m_code == 0);
            if (bus.ld) begin
                m_code = int'(bus.ld_val);
                m_sat  = 0;
            end else if (bus.en) begin
`ifdef FB_CODE_SAT_EN
                m_sat = lim;
                if (!lim) m_code = (m_code + (bus.u_d ? 1 : 65535)) % 65536;
`else
                m_sat  = 0;
                m_code = (m_code + (bus.u_d ? 1 : 65535)) % 65536;
`endif
            end else m_sat = 0;
        end
    endtask
    task automatic compare_all();
        chk("gray", 32'(bus.gray), 32'(m_gray));
        chk("strobe", 32'(bus.strobe), 32'(m_strobe));
        chk("strobe_onehot", 32'($countones(bus.strobe) <= 1), 32'd1);
        chk("frame_start", 32'(bus.frame_start), 32'(m_fs));
        chk("code", 32'(bus.code), 32'(m_code));
        chk("code_sel", 32'(bus.code_sel), 32'(m_code >> (CW - SEL)));
        chk("sat", 32'(bus.sat), 32'(m_sat));
        foreach (cnt[i]) cnt[i] += int'(bus.strobe[i]);
        if (m_fs != 0) begin
            foreach (cnt[i]) begin
                chk($sformatf("strobe_cnt%0d", i), 32'(cnt[i]), 32'((i < GW - 2) ? (1 << (GW - 2 - i)) : 2));
                cnt[i] = 0;
            end
        end
    endtask
    task automatic step();
        @(posedge clk);
        if (rstb) model_update();
        @(negedge clk);
        compare_all();
    endtask
    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask
    task automatic run_to(input int b);
        for (int k = 0; k < 2 * FRAME && m_bin != b; k++) step();
        chk("run_to_bin", 32'(m_bin), 32'(b));
    endtask
    task automatic do_reset();
        rstb = 1'b0;
        #1;
        model_reset();
        chk("rst_gray", 32'(bus.gray), 32'd0);
        chk("rst_out", {bus.strobe, bus.frame_start, bus.sat, bus.code}, 32'd0);
        compare_all();
        run(2);
        rstb = 1'b1;
    endtask
    task automatic fs_latency();
        int n;
        n = 0;
        for (int k = 1; k <= 3 * FRAME; k++) begin
            step();
            if (bus.frame_start) begin
                n = k;
                break;
            end
        end
        chk("fs_latency", 32'(n), 32'(FRAME));
    endtask
    initial begin
        bus.u_d = 1'b0; bus.en = 1'b0; bus.ld = 1'b0; bus.ld_val = '0;
        @(negedge clk);
        do_reset();
        fs_latency();
        bus.en = 1'b1; bus.u_d = 1'b1;
        run(3 * FRAME);
        chk("up3", 32'(bus.code), 32'd3);
        bus.ld = 1'b1; bus.ld_val = 16'h8000; bus.en = 1'b1; bus.u_d = 1'b0;
        run(FRAME);
        chk("ld_wins", 32'(bus.code), 32'h8000);
        chk("ld_sel", 32'(bus.code_sel), 32'h4);
        bus.ld = 1'b0; bus.en = 1'b0;
        run_to(5);
        bus.en = 1'b1;
        step();
        bus.en = 1'b0;
        run_to(0);
        chk("en_midframe", 32'(bus.code), 32'h8000);
        bus.ld = 1'b1; bus.ld_val = 16'hFFFF;
        run(FRAME);
        bus.ld = 1'b0; bus.en = 1'b1; bus.u_d = 1'b1;
        run(FRAME);
`ifdef FB_CODE_SAT_EN
        chk("up_limit", {bus.sat, 15'd0, bus.code}, {1'b1, 15'd0, 16'hFFFF});
`else
        chk("up_limit", {bus.sat, 15'd0, bus.code}, 32'd0);
`endif
        bus.ld = 1'b1; bus.ld_val = 16'h0000; bus.en = 1'b0;
        run(FRAME);
        bus.ld = 1'b0; bus.en = 1'b1; bus.u_d = 1'b0;
        run(FRAME);
`ifdef FB_CODE_SAT_EN
        chk("down_limit", {bus.sat, 15'd0, bus.code}, {1'b1, 15'd0, 16'h0000});
`else
        chk("down_limit", {bus.sat, 15'd0, bus.code}, {1'b0, 15'd0, 16'hFFFF});
`endif
        bus.en = 1'b0;
        run(FRAME);
        chk("sat_clear", 32'(bus.sat), 32'd0);
        run_to(9);
        do_reset();
        fs_latency();
        for (int k = 0; k < 40 * FRAME; k++) begin
            bus.en     = ($urandom_range(0, 3) != 0);
            bus.u_d    = $urandom_range(0, 1) == 1;
            bus.ld     = ($urandom_range(0, 15) == 0);
            bus.ld_val = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'h0000) : 16'($urandom);
            step();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
